// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
`timescale 1ns/1ps
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the priority pointer moves only on an accepted grant.
`timescale 1ns/1ps
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = REQ_IF;
        if (req_i == 2'b11) begin
            gnt_id_o = ~last_q;
        end else if (req_i[REQ_LS]) begin
            gnt_id_o = REQ_LS;
        end
        if (|req_i) begin
            gnt_o[gnt_id_o] = 1'b1;
        end
        last_d = accept_i ? gnt_id_o : last_q;
    end

    // Starting with IF as "last" hands the first tie to LS.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_IF;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and LS requesters onto one single-port RAM, one transaction at a time.
`timescale 1ns/1ps
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_W,
    parameter int DATA_WIDTH = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_rsp_valid,
    output logic [DATA_WIDTH-1:0] ls_rsp_data,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  id_q, id_d;

    logic [1:0]            req, gnt;
    logic                  gnt_id, idle, accept, rsp_fire;
    logic [DATA_WIDTH-1:0] rsp_data;

    assign req    = {ls_req_valid, if_req_valid};
    assign idle   = (state_q == ST_IDLE) && !reset;
    assign accept = idle && (|req);

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req),
        .accept_i (accept),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign if_req_ready = idle && gnt[REQ_IF];
    assign ls_req_ready = idle && gnt[REQ_LS];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACCESS;
                    id_d    = gnt_id;
                    if (gnt_id == REQ_LS) begin
                        addr_d  = ls_addr;
                        we_d    = ls_we;
                        wdata_d = ls_wdata;
                    end else begin
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                    end
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            id_q    <= REQ_IF;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            id_q    <= id_d;
        end
    end

    // Captured regs only change on acceptance, so the RAM bus holds its last value
    // outside ACCESS. Reset gates the strobes so an aborted write never lands.
    assign ram_address      = addr_q;
    assign ram_data_in      = wdata_q;
    assign ram_write_enable = (state_q == ST_ACCESS) && we_q && !reset;

    assign rsp_fire     = (state_q == ST_RESP) && !reset;
    assign rsp_data     = we_q ? '0 : ram_data_out;
    assign if_rsp_valid = rsp_fire && (id_q == REQ_IF);
    assign ls_rsp_valid = rsp_fire && (id_q == REQ_LS);
    assign if_rsp_data  = if_rsp_valid ? rsp_data : '0;
    assign ls_rsp_data  = ls_rsp_valid ? rsp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural single-port RAM.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req_valid = 1'b0, if_req_ready, if_rsp_valid;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rsp_data;
    logic          ls_req_valid = 1'b0, ls_req_ready, ls_we = 1'b0, ls_rsp_valid;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0, ls_rsp_data;
    logic          ram_write_enable;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .ram_write_enable(ram_write_enable), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    // RAM model: registered read of the address sampled at the edge
    logic [DW-1:0] mem    [256];
    logic [DW-1:0] shadow [256];
    always @(posedge clk) begin
        ram_data_out <= mem[ram_address[7:0]];
        if (ram_write_enable) mem[ram_address[7:0]] = ram_data_in;
    end

    int n_tests = 0, n_fail = 0, cyc = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic          gnt_log[$];
    int            acc_cyc[$];
    int            busy = 0, we_cnt = 0;
    int            if_acc_cnt = 0, if_rsp_cnt = 0, ls_rsp_cnt = 0;
    logic [DW-1:0] last_if_data = '0, last_ls_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            busy = 0;
            chk("we_in_reset", ram_write_enable, 0);
            chk("rsp_in_reset", {if_rsp_valid, ls_rsp_valid}, 0);
        end else begin
            chk("rsp_excl", if_rsp_valid && ls_rsp_valid, 0);
            if (busy > 0) begin
                chk("rdy_busy", {if_req_ready, ls_req_ready}, 0);
                busy--;
            end
            if (ram_write_enable) begin
                we_cnt++;
                if (sb.size() > 0) begin
                    chk("we_addr", ram_address, sb[0].addr);
                    chk("we_data", ram_data_in, sb[0].wdata);
                end
            end
            if (if_rsp_valid || ls_rsp_valid) begin
                if (if_rsp_valid) begin if_rsp_cnt++; last_if_data = if_rsp_data; end
                if (ls_rsp_valid) begin ls_rsp_cnt++; last_ls_data = ls_rsp_data; end
                if (sb.size() == 0) begin
                    chk("unexp_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", ls_rsp_valid, e.id);
                    chk("rsp_data", ls_rsp_valid ? ls_rsp_data : if_rsp_data, e.data);
                    chk("rsp_lat", cyc - e.cyc, 2);
                    chk("we_pulses", we_cnt, e.we ? 1 : 0);
                    if (e.we) shadow[e.addr[7:0]] = e.wdata;
                end
            end
            if ((if_req_valid && if_req_ready) || (ls_req_valid && ls_req_ready)) begin
                chk("rdy_excl", if_req_ready && ls_req_ready, 0);
                e.id    = (ls_req_valid && ls_req_ready) ? REQ_LS : REQ_IF;
                e.we    = (e.id == REQ_LS) ? ls_we : 1'b0;
                e.addr  = (e.id == REQ_LS) ? ls_addr : if_addr;
                e.wdata = ls_wdata;
                e.data  = e.we ? '0 : shadow[e.addr[7:0]];
                e.cyc   = cyc;
                sb.push_back(e);
                gnt_log.push_back(e.id);
                acc_cyc.push_back(cyc);
                if (e.id == REQ_IF) if_acc_cnt++;
                we_cnt = 0;
                busy   = 2;
            end
        end
    end

    task automatic do_if(input logic [AW-1:0] a);
        @(posedge clk); #1;
        if_req_valid = 1'b1;
        if_addr      = a;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_req_ready) begin
                @(posedge clk); #1;
                if_req_valid = 1'b0;
                return;
            end
        end
        chk("if_acc_timeout", 0, 1);
        if_req_valid = 1'b0;
    endtask

    task automatic do_ls(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        ls_req_valid = 1'b1;
        ls_we        = we;
        ls_addr      = a;
        ls_wdata     = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ls_req_ready) begin
                @(posedge clk); #1;
                ls_req_valid = 1'b0;
                return;
            end
        end
        chk("ls_acc_timeout", 0, 1);
        ls_req_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0, cnt1;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'(i) * 32'h0101_0101;
            shadow[i] = mem[i];
        end
        mem[4]     = 32'hA5A5_A5A5; shadow[4]  = 32'hA5A5_A5A5;
        mem[16]    = 32'h0BAD_F00D; shadow[16] = 32'h0BAD_F00D;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rdy", {if_req_ready, ls_req_ready}, 0);
        chk("rst_rsp", {if_rsp_valid, ls_rsp_valid}, 0);
        chk("rst_we", ram_write_enable, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_wdata", ram_data_in, 0);

        // IF read of preloaded word
        do_if(4);
        repeat (3) @(posedge clk);
        chk("if_read_a5", last_if_data, 32'hA5A5_A5A5);

        // LS write then read back
        do_ls(1'b1, 8, 32'h1234_5678);
        repeat (3) @(posedge clk);
        chk("ls_wr_rsp0", last_ls_data, 0);
        do_ls(1'b0, 8, '0);
        repeat (3) @(posedge clk);
        chk("ls_rd_back", last_ls_data, 32'h1234_5678);

        // Ties after reset alternate starting with LS
        do_reset();
        gnt_log.delete();
        for (int k = 0; k < 2; k++) begin
            fork
                do_if(20);
                do_ls(1'b0, 24, '0);
            join
        end
        repeat (4) @(posedge clk);
        chk("tie_cnt", gnt_log.size(), 4);
        if (gnt_log.size() == 4) begin
            chk("tie0", gnt_log[0], REQ_LS);
            chk("tie1", gnt_log[1], REQ_IF);
            chk("tie2", gnt_log[2], REQ_LS);
            chk("tie3", gnt_log[3], REQ_IF);
        end

        // Back-to-back IF reads
        acc_cyc.delete();
        for (int k = 0; k < 10; k++) do_if(32'(k * 4));
        repeat (4) @(posedge clk);
        chk("b2b_cnt", acc_cyc.size(), 10);
        for (int k = 1; k < acc_cyc.size(); k++)
            chk("b2b_gap", acc_cyc[k] - acc_cyc[k-1], 3);

        // IF valid blips while LS owns the RAM
        cnt0 = if_acc_cnt;
        cnt1 = if_rsp_cnt;
        fork
            do_ls(1'b0, 12, '0);
            begin
                repeat (2) @(posedge clk);
                #1 if_req_valid = 1'b1; if_addr = 40;
                @(posedge clk);
                #1 if_req_valid = 1'b0;
            end
        join
        repeat (6) @(posedge clk);
        chk("drop_no_acc", if_acc_cnt, cnt0);
        chk("drop_no_rsp", if_rsp_cnt, cnt1);

        // Reset during ACCESS of an LS write aborts it
        cnt0 = ls_rsp_cnt;
        do_ls(1'b1, 16, 32'hDEAD_BEEF);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        chk("abort_no_rsp", ls_rsp_cnt, cnt0);
        chk("abort_ram16", mem[16], 32'h0BAD_F00D);
        @(posedge clk); #1;
        if_req_valid = 1'b1;
        if_addr      = 16;
        @(negedge clk);
        chk("abort_idle_rdy", if_req_ready, 1);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        repeat (3) @(posedge clk);
        chk("abort_rd16", last_if_data, 32'h0BAD_F00D);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports for the instruction-fetch (IF) requester, read-only:
- if_req_valid  input  1  request present.
- if_req_ready  output  1  request accepted this cycle.
- if_addr  input  ADDR_WIDTH  read address.
- if_rsp_valid  output  1  one-cycle response strobe.
- if_rsp_data  output  DATA_WIDTH  read data.
REQ-006 SHALL have ports for the load/store (LS) requester:
- ls_req_valid  input  1  request present.
- ls_req_ready  output  1  request accepted this cycle.
- ls_we  input  1  1 = write, 0 = read.
- ls_addr  input  ADDR_WIDTH  address.
- ls_wdata  input  DATA_WIDTH  write data.
- ls_rsp_valid  output  1  one-cycle completion strobe.
- ls_rsp_data  output  DATA_WIDTH  read data; 0 for writes.
REQ-007 SHALL have ports for the shared single-port RAM:
- ram_write_enable  output  1  RAM write strobe.
- ram_address  output  ADDR_WIDTH  RAM address.
- ram_data_in  output  DATA_WIDTH  RAM write data.
- ram_data_out  input  DATA_WIDTH  RAM read data, valid one cycle after the address is sampled.

Function
REQ-008 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction in flight at a time.
REQ-009 In IDLE, SHALL assert exactly one req_ready, combinationally, for the arbitration winner when any req_valid is high; a request is accepted when valid && ready; both readies are 0 outside IDLE.
REQ-010 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-011 On acceptance, SHALL register the address, we (IF forced 0) and wdata, and the winner ID; move to ACCESS.
REQ-012 In ACCESS, SHALL drive ram_address and ram_data_in from the registers; ram_write_enable = registered we; move to RESP.
REQ-013 In RESP, SHALL pulse the winner's rsp_valid for exactly one cycle; read rsp_data = ram_data_out; write rsp_data = 0; move to IDLE.
REQ-014 Latency from acceptance edge to rsp_valid SHALL be 2 cycles; peak throughput SHALL be one transaction per 3 cycles.
REQ-015 ram_write_enable SHALL be 0 in every state except ACCESS of a write.
REQ-016 ram_address and ram_data_in SHALL hold their last value outside ACCESS.
REQ-017 Addresses SHALL pass unmodified; no alignment check or translation.
REQ-018 There SHALL be no response backpressure; a requester must consume rsp_valid when it is pulsed.
REQ-019 A req_valid deasserted before acceptance SHALL leave no state change.
REQ-020 The non-winning rsp_valid SHALL stay 0; both rsp_valid SHALL never be high together.

Reset
REQ-021 On reset, SHALL enter IDLE, set last-grant = IF (LS wins first tie), and clear all registered outputs and captured registers to 0.
REQ-022 Reset mid-transaction SHALL abort it: no rsp_valid and no ram_write_enable is issued for it afterwards.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the FSM state enum, requester ID constants (REQ_IF = 0, REQ_LS = 1) and default widths.
REQ-024 Round-robin logic SHALL be a sub-module rr_arbiter2 (two requests, update-on-accept, grant outputs).

Verification
REQ-025 IF read only: preload RAM[4] = A5A5A5A5; if_addr = 4 accepted at cycle N -> if_rsp_valid at N+2, if_rsp_data = A5A5A5A5.
REQ-026 LS write then read: write 12345678 to addr 8 -> ls_rsp_valid with data 0, ram_write_enable high for exactly 1 cycle; read addr 8 -> 12345678.
REQ-027 Tie after reset: both valid -> LS granted first, IF next, alternating over 4 transactions.
REQ-028 Sustained IF traffic: 10 back-to-back reads -> accepts spaced exactly 3 cycles apart; readies 0 in ACCESS and RESP.
REQ-029 Reset asserted during ACCESS of an LS write to addr 16 -> no ls_rsp_valid; RAM[16] unchanged; FSM in IDLE.
REQ-030 Early drop: IF valid raised then lowered while LS owns the RAM -> no IF acceptance and no if_rsp_valid.
